// File: rtl/punc_control_pkg.sv
// rtl/punc_control_pkg.sv - opcodes, FSM states, select encodings and control word for PUnC
package punc_control_pkg;

  // LC3 opcodes, ir[15:12]
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RSV0 = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV1 = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXECUTE  = 3'd2,
    ST_EXECUTE2 = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  localparam logic [1:0] MEM_W_ADDR_PC_OFF9 = 2'd0;
  localparam logic [1:0] MEM_W_ADDR_R1_OFF6 = 2'd1;
  localparam logic [1:0] MEM_W_ADDR_MAR     = 2'd2;

  localparam logic       MEM_W_DATA_R0  = 1'b0;
  localparam logic       MEM_W_DATA_MEM = 1'b1;

  localparam logic [1:0] MEM_R_ADDR_PC      = 2'd0;
  localparam logic [1:0] MEM_R_ADDR_PC_OFF9 = 2'd1;
  localparam logic [1:0] MEM_R_ADDR_R0_OFF6 = 2'd2;
  localparam logic [1:0] MEM_R_ADDR_MAR     = 2'd3;

  localparam logic       RF_R0_ADDR_8_6  = 1'b0;
  localparam logic       RF_R0_ADDR_11_9 = 1'b1;
  localparam logic       RF_R1_ADDR_2_0  = 1'b0;
  localparam logic       RF_R1_ADDR_8_6  = 1'b1;

  localparam logic [1:0] RF_W_DATA_ALU     = 2'd0;
  localparam logic [1:0] RF_W_DATA_MEM     = 2'd1;
  localparam logic [1:0] RF_W_DATA_PC      = 2'd2;
  localparam logic [1:0] RF_W_DATA_PC_OFF9 = 2'd3;

  localparam logic       RF_W_ADDR_11_9 = 1'b0;
  localparam logic       RF_W_ADDR_R7   = 1'b1;

  localparam logic [1:0] PC_LD_DATA_PC_OFF9  = 2'd0;
  localparam logic [1:0] PC_LD_DATA_R0       = 2'd1;
  localparam logic [1:0] PC_LD_DATA_PC_OFF11 = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_ADDI = 3'd1;
  localparam logic [2:0] ALU_NOT  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_ANDI = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;

  localparam logic       COND_LD_DATA_ALU  = 1'b0;
  localparam logic       COND_LD_DATA_RF_W = 1'b1;

  // Every control output in one word; field order is also the bus order
  typedef struct packed {
    logic       mem_w_en;
    logic [1:0] mem_w_addr_sel;
    logic       mem_w_data_sel;
    logic [1:0] mem_r_addr_sel;
    logic       mar_ld;
    logic       rf_w_en;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_ld_data_sel;
    logic [2:0] alu_sel;
    logic       cond_ld;
    logic       cond_ld_data_sel;
    logic       halted;
  } ctrl_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == OP_RSV0) || (op == OP_RSV1);
  endfunction

endpackage

// File: rtl/punc_control_if.sv
// rtl/punc_control_if.sv - control/datapath bundle between punc_control and the PUnC datapath
interface punc_control_if;
  logic [15:0] ir;
  logic        n;
  logic        z;
  logic        p;
  logic        mem_w_en;
  logic [1:0]  mem_w_addr_sel;
  logic        mem_w_data_sel;
  logic [1:0]  mem_r_addr_sel;
  logic        mar_ld;
  logic        rf_w_en;
  logic        rf_r0_addr_sel;
  logic        rf_r1_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_w_addr_sel;
  logic        ir_ld;
  logic        pc_ld;
  logic        pc_clr;
  logic        pc_inc;
  logic [1:0]  pc_ld_data_sel;
  logic [2:0]  alu_sel;
  logic        cond_ld;
  logic        cond_ld_data_sel;
  logic        halted;

  modport master (
    input  ir, n, z, p,
    output mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel, mar_ld,
           rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel,
           ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel,
           cond_ld, cond_ld_data_sel, halted
  );

  modport slave (
    output ir, n, z, p,
    input  mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel, mar_ld,
           rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel,
           ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel,
           cond_ld, cond_ld_data_sel, halted
  );
endinterface

// File: rtl/punc_decode.sv
// rtl/punc_decode.sv - opcode to control word lookup for the EXECUTE and EXECUTE2 cycles
module punc_decode
  import punc_control_pkg::*;
(
  input  logic [3:0] op,
  input  logic [2:0] nzp_mask,
  input  logic       imm,
  input  logic       n,
  input  logic       z,
  input  logic       p,
  input  logic       second,
  output ctrl_t      ctrl
);

  logic br_taken;

  // A zero mask can never match, so BR with ir[11:9]=000 falls through
  assign br_taken = (nzp_mask[2] & n) | (nzp_mask[1] & z) | (nzp_mask[0] & p);

  // Control word for the current execute cycle; reserved opcodes yield all zeros
  always_comb begin
    ctrl = '0;
    if (second) begin
      case (op)
        OP_LDI: begin
          ctrl.mem_r_addr_sel   = MEM_R_ADDR_MAR;
          ctrl.rf_w_data_sel    = RF_W_DATA_MEM;
          ctrl.rf_w_en          = 1'b1;
          ctrl.cond_ld          = 1'b1;
          ctrl.cond_ld_data_sel = COND_LD_DATA_RF_W;
        end
        OP_STI: begin
          ctrl.mem_w_addr_sel = MEM_W_ADDR_MAR;
          ctrl.mem_w_data_sel = MEM_W_DATA_R0;
          ctrl.rf_r0_addr_sel = RF_R0_ADDR_11_9;
          ctrl.mem_w_en       = 1'b1;
        end
        default: ;
      endcase
    end else begin
      case (op)
        OP_ADD, OP_AND, OP_NOT: begin
          ctrl.rf_r0_addr_sel   = RF_R0_ADDR_8_6;
          ctrl.rf_r1_addr_sel   = RF_R1_ADDR_2_0;
          if (op == OP_NOT)      ctrl.alu_sel = ALU_NOT;
          else if (op == OP_ADD) ctrl.alu_sel = imm ? ALU_ADDI : ALU_ADD;
          else                   ctrl.alu_sel = imm ? ALU_ANDI : ALU_AND;
          ctrl.rf_w_data_sel    = RF_W_DATA_ALU;
          ctrl.rf_w_addr_sel    = RF_W_ADDR_11_9;
          ctrl.rf_w_en          = 1'b1;
          ctrl.cond_ld          = 1'b1;
          ctrl.cond_ld_data_sel = COND_LD_DATA_ALU;
        end
        OP_BR: begin
          ctrl.pc_ld_data_sel = PC_LD_DATA_PC_OFF9;
          ctrl.pc_ld          = br_taken;
        end
        OP_JMP: begin
          ctrl.rf_r0_addr_sel = RF_R0_ADDR_8_6;
          ctrl.pc_ld_data_sel = PC_LD_DATA_R0;
          ctrl.pc_ld          = 1'b1;
        end
        OP_JSR: begin
          // R7 write and pc load share the edge, so JSRR R7 reads the old R7
          ctrl.rf_w_en        = 1'b1;
          ctrl.rf_w_addr_sel  = RF_W_ADDR_R7;
          ctrl.rf_w_data_sel  = RF_W_DATA_PC;
          ctrl.pc_ld          = 1'b1;
          ctrl.rf_r0_addr_sel = RF_R0_ADDR_8_6;
          ctrl.pc_ld_data_sel = nzp_mask[2] ? PC_LD_DATA_PC_OFF11 : PC_LD_DATA_R0;
        end
        OP_LD, OP_LDR: begin
          ctrl.mem_r_addr_sel   = (op == OP_LD) ? MEM_R_ADDR_PC_OFF9 : MEM_R_ADDR_R0_OFF6;
          ctrl.rf_r0_addr_sel   = RF_R0_ADDR_8_6;
          ctrl.rf_w_data_sel    = RF_W_DATA_MEM;
          ctrl.rf_w_en          = 1'b1;
          ctrl.cond_ld          = 1'b1;
          ctrl.cond_ld_data_sel = COND_LD_DATA_RF_W;
        end
        OP_LEA: begin
          ctrl.rf_w_data_sel    = RF_W_DATA_PC_OFF9;
          ctrl.rf_w_en          = 1'b1;
          ctrl.cond_ld          = 1'b1;
          ctrl.cond_ld_data_sel = COND_LD_DATA_RF_W;
        end
        OP_ST: begin
          ctrl.mem_w_addr_sel = MEM_W_ADDR_PC_OFF9;
          ctrl.mem_w_data_sel = MEM_W_DATA_R0;
          ctrl.rf_r0_addr_sel = RF_R0_ADDR_11_9;
          ctrl.mem_w_en       = 1'b1;
        end
        OP_STR: begin
          ctrl.mem_w_addr_sel = MEM_W_ADDR_R1_OFF6;
          ctrl.rf_r1_addr_sel = RF_R1_ADDR_8_6;
          ctrl.rf_r0_addr_sel = RF_R0_ADDR_11_9;
          ctrl.mem_w_data_sel = MEM_W_DATA_R0;
          ctrl.mem_w_en       = 1'b1;
        end
        OP_LDI, OP_STI: begin
          ctrl.mem_r_addr_sel = MEM_R_ADDR_PC_OFF9;
          ctrl.mar_ld         = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/punc_control.sv
// rtl/punc_control.sv - multi-cycle FETCH/DECODE/EXECUTE control FSM for the PUnC LC3
module punc_control
  import punc_control_pkg::*;
#(
  parameter bit RESERVED_AS_HALT = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  punc_control_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl;
  ctrl_t      dec_ctrl;
  logic [3:0] op;
  logic       unused_ir_bits;

  assign op             = bus.ir[15:12];
  assign unused_ir_bits = ^{bus.ir[8:6], bus.ir[4:0]};

  punc_decode u_decode (
    .op       (op),
    .nzp_mask (bus.ir[11:9]),
    .imm      (bus.ir[5]),
    .n        (bus.n),
    .z        (bus.z),
    .p        (bus.p),
    .second   (state_q == ST_EXECUTE2),
    .ctrl     (dec_ctrl)
  );

  // State register; reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next state and control word; reset overrides everything with pc_clr only
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    if (rst) begin
      ctrl.pc_clr = 1'b1;
      state_d     = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ctrl.mem_r_addr_sel = MEM_R_ADDR_PC;
          ctrl.ir_ld          = 1'b1;
          ctrl.pc_inc         = 1'b1;
          state_d             = ST_DECODE;
        end
        ST_DECODE: begin
          if (op == OP_HALT || (RESERVED_AS_HALT && is_reserved(op))) state_d = ST_HALT;
          else                                                        state_d = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          ctrl    = dec_ctrl;
          state_d = (op == OP_LDI || op == OP_STI) ? ST_EXECUTE2 : ST_FETCH;
        end
        ST_EXECUTE2: begin
          ctrl    = dec_ctrl;
          state_d = ST_FETCH;
        end
        ST_HALT: begin
          ctrl.halted = 1'b1;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign {bus.mem_w_en, bus.mem_w_addr_sel, bus.mem_w_data_sel, bus.mem_r_addr_sel,
          bus.mar_ld, bus.rf_w_en, bus.rf_r0_addr_sel, bus.rf_r1_addr_sel,
          bus.rf_w_data_sel, bus.rf_w_addr_sel, bus.ir_ld, bus.pc_ld, bus.pc_clr,
          bus.pc_inc, bus.pc_ld_data_sel, bus.alu_sel, bus.cond_ld,
          bus.cond_ld_data_sel, bus.halted} = ctrl;

endmodule
